timer_deadtime_gen: RTL and testbench
=====================================

# timer_deadtime_gen

Complementary-output dead-time inserter for the advanced timer, directly downstream of a timer's four PWM channel outputs. Each channel's single-ended PWM is turned into a high-side/low-side pair. Both sides are held inactive for a programmable number of clock cycles around every edge, so external half-bridges never conduct simultaneously. Configuration comes from the APB register block through shadow registers, and a sticky flag per channel reports PWM pulses that were swallowed by the dead-time.

## Interface
Parameters:
- N_CH, 4, number of PWM channels (one per timer comparator output)
- DT_BITS, 8, width of the dead-time counters and config fields

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_enable_i  in  1  unshadowed; 0 forces all channels to OFF
- cfg_update_i  in  1  single-cycle pulse; copies all cfg_* shadow fields
- cfg_dt_rise_i  in  DT_BITS  cycles of dead time before high side turns on
- cfg_dt_fall_i  in  DT_BITS  cycles of dead time before low side turns on
- cfg_pol_hs_i  in  1  high-side polarity: 0 = active-high, 1 = active-low
- cfg_pol_ls_i  in  1  low-side polarity, same encoding
- cfg_clr_i  in  1  single-cycle pulse; clears all sticky flags
- pwm_i  in  N_CH  PWM from the timer comparators; synchronous to clk_i
- pwm_hs_o  out  N_CH  high-side drive
- pwm_ls_o  out  N_CH  low-side drive
- short_o  out  N_CH  sticky flag: a pulse shorter than the dead time was suppressed

## Operation
- **Shadow registers.** dt_rise, dt_fall, pol_hs and pol_ls load on the cfg_update_i edge. A dead-time interval already in progress keeps its loaded count; the new values apply from the next dead-time entry.
- **Input register.** Each channel registers pwm_i into pwm_q. The FSM uses only pwm_q.
- **Per-channel FSM states:** OFF, LS_ON, DT_LH, HS_ON, DT_HL.
  - OFF: both outputs inactive.
  - OFF with enable=1: pwm_q=1 → DT_LH; pwm_q=0 → DT_HL.
  - LS_ON with pwm_q=1 → DT_LH.
  - HS_ON with pwm_q=0 → DT_HL.
  - DT_LH with pwm_q still 1 and cnt==0 → HS_ON.
  - DT_LH with pwm_q back to 0 → LS_ON immediately; sets short flag.
  - DT_HL with pwm_q still 0 and cnt==0 → LS_ON.
  - DT_HL with pwm_q back to 1 → HS_ON immediately; sets short flag.
  - Any state with enable=0 → OFF. This has priority over every other transition.
- **Counter.** On DT_LH entry cnt ← dt_rise−1; on DT_HL entry cnt ← dt_fall−1. In a DT state, cnt decrements each cycle, and the state exits when cnt==0.
  - A DT field of N>0 gives exactly N cycles with both sides inactive.
  - N=0 skips the DT state entirely: a direct LS_ON↔HS_ON swap on the same edge, with no overlap.
- **Output decode.**
  - hs_active = (state==HS_ON); ls_active = (state==LS_ON).
  - pwm_hs_o = hs_active XOR pol_hs; pwm_ls_o = ls_active XOR pol_ls.
  - Outputs are flops loaded from next-state decode, so they change on the same edge as the state.
- **Sticky flag.** short_o bit sets on a suppressed pulse and stays set until cfg_clr_i. If set and clear occur in the same cycle, set wins.

## Timing
- **Reset values.** State OFF; cnt 0; pwm_q 0; all shadow fields 0; pwm_hs_o 0; pwm_ls_o 0; short_o 0.
- **Input latency.** pwm_i is sampled at edge k, so pwm_q changes at edge k. The state change and output change happen at edge k+1: one cycle from pwm_q to outputs.
- **Falling input (HS_ON → LS_ON).** pwm_hs_o goes inactive at k+1 and pwm_ls_o goes active at k+1+dt_fall. Rising input mirrors this with dt_rise.
- **Enable.** Deassertion sampled at edge m gives inactive outputs at edge m. Reassertion enters the DT state at the next edge, so outputs stay inactive for a full dead time.
- **Update during dead time.** A cfg_update_i pulse in the same cycle as a DT entry loads cnt from the old shadow value.
- **Polarity change.** Takes effect on the output flops at the edge after the update edge.

## Structure
- Package timer_deadtime_pkg holds:
  - dt_state_e: enum of OFF, LS_ON, DT_LH, HS_ON, DT_HL.
  - DT_BITS_DEF = 8.
- Sub-module timer_dt_channel is instantiated N_CH times in a generate loop. It contains pwm_q, the FSM, cnt, the output flops and the sticky flag.
- The top level holds only the shadow registers and the fan-out of the shared config.

## Test plan
1. **Reset and enable.** Release reset, dt_rise=dt_fall=3 updated, enable=1, pwm_i=0.
   - Expected: outputs 0 through reset; pwm_ls_o[0]=1 exactly 3 cycles after DT_HL entry; pwm_hs_o stays 0.
2. **Steady edges.** Square wave on pwm_i[0], period 20, dt_rise=2, dt_fall=5.
   - Expected: each rise gives hs on 2 cycles after ls off; each fall gives ls on 5 cycles after hs off.
   - Never both active; all latencies match the Timing section.
3. **Short pulse.** dt_rise=6, 3-cycle high pulse on pwm_i[1].
   - Expected: pwm_hs_o[1] never asserts; pwm_ls_o[1] returns active; short_o[1]=1 until cfg_clr_i.
   - Check set-wins when clear and set collide.
4. **Zero dead time and polarity.** dt=0, pol_hs=pol_ls=1 updated.
   - Expected: outputs swap on the same edge with no overlap; idle level 1 when enable=0.
5. **Enable and update mid-operation.**
   - Drop enable in the middle of DT_LH: outputs go inactive and FSM is OFF at the sampling edge.
   - Update dt_fall 4→10 in the middle of DT_HL: the current interval finishes at 4, the next lasts 10.
6. **Mid-operation reset.** Assert rstn_i during HS_ON.
   - Expected: all outputs and flags 0 asynchronously; shadows back to 0.

Source files
------------

// File: rtl/timer_deadtime_pkg.sv
// Shared types for the complementary-output dead-time inserter.
package timer_deadtime_pkg;

    localparam int DT_BITS_DEF = 8;

    typedef enum logic [2:0] {
        OFF,
        LS_ON,
        DT_LH,
        HS_ON,
        DT_HL
    } dt_state_e;

endpackage

// File: rtl/timer_dt_channel.sv
// One complementary channel: input register, dead-time FSM,
// output flops and sticky short-pulse flag.
module timer_dt_channel
    import timer_deadtime_pkg::*;
#(
    parameter int DT_BITS = DT_BITS_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [DT_BITS-1:0] i_dt_rise,
    input  logic [DT_BITS-1:0] i_dt_fall,
    input  logic               i_pol_hs,
    input  logic               i_pol_ls,
    input  logic               i_clr,
    input  logic               i_pwm,
    output logic               o_hs,
    output logic               o_ls,
    output logic               o_short
);

    dt_state_e          r_state;
    dt_state_e          w_state_nx;
    logic [DT_BITS-1:0] r_cnt;
    logic [DT_BITS-1:0] w_cnt_nx;
    logic               r_pwm_q;
    logic               r_hs;
    logic               r_ls;
    logic               r_short;
    logic               w_short_set;
    logic               w_rise_zero;
    logic               w_fall_zero;

    assign w_rise_zero = (i_dt_rise == '0);
    assign w_fall_zero = (i_dt_fall == '0);

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_short_set = 1'b0;
        if (!i_en) begin
            w_state_nx = OFF;
            w_cnt_nx   = '0;
        end else begin
            unique case (r_state)
                OFF, LS_ON, HS_ON: begin
                    // A zero dead time swaps sides directly on this edge
                    if (r_pwm_q && (r_state != HS_ON)) begin
                        w_state_nx = w_rise_zero ? HS_ON : DT_LH;
                        w_cnt_nx   = w_rise_zero ? '0 : i_dt_rise - DT_BITS'(1);
                    end else if (!r_pwm_q && (r_state != LS_ON)) begin
                        w_state_nx = w_fall_zero ? LS_ON : DT_HL;
                        w_cnt_nx   = w_fall_zero ? '0 : i_dt_fall - DT_BITS'(1);
                    end
                end
                DT_LH: begin
                    if (!r_pwm_q) begin
                        w_state_nx  = LS_ON;
                        w_cnt_nx    = '0;
                        w_short_set = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_state_nx = HS_ON;
                    end else begin
                        w_cnt_nx = r_cnt - DT_BITS'(1);
                    end
                end
                DT_HL: begin
                    if (r_pwm_q) begin
                        w_state_nx  = HS_ON;
                        w_cnt_nx    = '0;
                        w_short_set = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_state_nx = LS_ON;
                    end else begin
                        w_cnt_nx = r_cnt - DT_BITS'(1);
                    end
                end
                default: begin
                    w_state_nx = OFF;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_pwm_q <= 1'b0;
            r_hs    <= 1'b0;
            r_ls    <= 1'b0;
            r_short <= 1'b0;
        end else begin
            r_pwm_q <= i_pwm;
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hs    <= (w_state_nx == HS_ON) ^ i_pol_hs;
            r_ls    <= (w_state_nx == LS_ON) ^ i_pol_ls;
            if (w_short_set) begin
                r_short <= 1'b1;
            end else if (i_clr) begin
                r_short <= 1'b0;
            end
        end
    end

    assign o_hs    = r_hs;
    assign o_ls    = r_ls;
    assign o_short = r_short;

endmodule

// File: rtl/timer_deadtime_gen.sv
// Dead-time inserter top: shadowed configuration fanned out to
// one complementary channel per timer PWM output.
module timer_deadtime_gen
    import timer_deadtime_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DT_BITS = DT_BITS_DEF
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cfg_enable_i,
    input  logic               cfg_update_i,
    input  logic [DT_BITS-1:0] cfg_dt_rise_i,
    input  logic [DT_BITS-1:0] cfg_dt_fall_i,
    input  logic               cfg_pol_hs_i,
    input  logic               cfg_pol_ls_i,
    input  logic               cfg_clr_i,
    input  logic [N_CH-1:0]    pwm_i,
    output logic [N_CH-1:0]    pwm_hs_o,
    output logic [N_CH-1:0]    pwm_ls_o,
    output logic [N_CH-1:0]    short_o
);

    logic [DT_BITS-1:0] r_dt_rise;
    logic [DT_BITS-1:0] r_dt_fall;
    logic               r_pol_hs;
    logic               r_pol_ls;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_dt_rise <= '0;
            r_dt_fall <= '0;
            r_pol_hs  <= 1'b0;
            r_pol_ls  <= 1'b0;
        end else if (cfg_update_i) begin
            r_dt_rise <= cfg_dt_rise_i;
            r_dt_fall <= cfg_dt_fall_i;
            r_pol_hs  <= cfg_pol_hs_i;
            r_pol_ls  <= cfg_pol_ls_i;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        timer_dt_channel #(
            .DT_BITS (DT_BITS)
        ) u_ch (
            .i_clk     (clk_i),
            .i_rst_n   (rstn_i),
            .i_en      (cfg_enable_i),
            .i_dt_rise (r_dt_rise),
            .i_dt_fall (r_dt_fall),
            .i_pol_hs  (r_pol_hs),
            .i_pol_ls  (r_pol_ls),
            .i_clr     (cfg_clr_i),
            .i_pwm     (pwm_i[g]),
            .o_hs      (pwm_hs_o[g]),
            .o_ls      (pwm_ls_o[g]),
            .o_short   (short_o[g])
        );
    end

endmodule

// File: tb/tb_timer_deadtime_gen.sv
// Scoreboard bench for timer_deadtime_gen: expected output vectors are
// queued per edge from the timing rules and compared after each edge.
module tb_timer_deadtime_gen;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic         en   = 1'b0;
    logic         upd  = 1'b0;
    logic         clr  = 1'b0;
    logic         phs  = 1'b0;
    logic         pls  = 1'b0;
    logic [W-1:0] dtr  = '0;
    logic [W-1:0] dtf  = '0;
    logic [N-1:0] pwm  = '0;
    logic [N-1:0] hs;
    logic [N-1:0] ls;
    logic [N-1:0] sh;

    typedef struct packed {
        logic [3:0] hs;
        logic [3:0] ls;
        logic [3:0] sh;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    timer_deadtime_gen #(
        .N_CH    (N),
        .DT_BITS (W)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .cfg_enable_i  (en),
        .cfg_update_i  (upd),
        .cfg_dt_rise_i (dtr),
        .cfg_dt_fall_i (dtf),
        .cfg_pol_hs_i  (phs),
        .cfg_pol_ls_i  (pls),
        .cfg_clr_i     (clr),
        .pwm_i         (pwm),
        .pwm_hs_o      (hs),
        .pwm_ls_o      (ls),
        .short_o       (sh)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int r, input int f, input logic ph, input logic pl);
        dtr = W'(r);
        dtf = W'(f);
        phs = ph;
        pls = pl;
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int t = 0; t < 5; t++) begin
            if (t == 3) begin
                #2 rstn = 1'b1;
            end
            q.push_back('0);
            tick();
            e = q.pop_front();
            n_chk++;
            if ({hs, ls, sh} !== e) begin
                n_fail++;
                $display("FAIL reset t=%0d got hs=%b ls=%b sh=%b exp hs=%b ls=%b sh=%b",
                         t, hs, ls, sh, e.hs, e.ls, e.sh);
            end
        end
    endtask

    task automatic test_enable();
        cfg(3, 3, 1'b0, 1'b0);
        en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            e.hs = 4'h0;
            e.ls = (t >= 3) ? 4'hF : 4'h0;
            e.sh = 4'h0;
            q.push_back(e);
            tick();
            e = q.pop_front();
            n_chk++;
            if ({hs, ls, sh} !== e) begin
                n_fail++;
                $display("FAIL enable t=%0d got hs=%b ls=%b sh=%b exp hs=%b ls=%b sh=%b",
                         t, hs, ls, sh, e.hs, e.ls, e.sh);
            end
        end
    endtask

    task automatic test_steady();
        int   age;
        logic p;
        logic h;
        logic l;
        age = 0;
        cfg(2, 5, 1'b0, 1'b0);
        for (int t = 0; t < 60; t++) begin
            p = ((t / 10) % 2) == 0;
            age = (t % 10 == 0) ? 0 : age + 1;
            pwm[0] = p;
            if (age == 0) begin
                h = !p;
                l = p;
            end else if (p) begin
                h = (age >= 1 + 2);
                l = 1'b0;
            end else begin
                h = 1'b0;
                l = (age >= 1 + 5);
            end
            e.hs = {3'b000, h};
            e.ls = {3'b111, l};
            e.sh = 4'h0;
            q.push_back(e);
            tick();
            e = q.pop_front();
            n_chk++;
            if ({hs, ls, sh} !== e) begin
                n_fail++;
                $display("FAIL steady t=%0d got hs=%b ls=%b sh=%b exp hs=%b ls=%b sh=%b",
                         t, hs, ls, sh, e.hs, e.ls, e.sh);
            end
        end
    endtask

    task automatic test_short();
        logic s1;
        logic l1;
        s1 = 1'b0;
        cfg(6, 5, 1'b0, 1'b0);
        for (int t = 0; t < 18; t++) begin
            pwm[1] = (t < 3) || (t >= 10 && t < 13);
            clr    = (t == 8) || (t == 14) || (t == 16);
            l1     = !((t >= 1 && t <= 3) || (t >= 11 && t <= 13));
            if (t == 4 || t == 14) begin
                s1 = 1'b1;
            end else if (clr) begin
                s1 = 1'b0;
            end
            e.hs = 4'h0;
            e.ls = {2'b11, l1, 1'b1};
            e.sh = {2'b00, s1, 1'b0};
            q.push_back(e);
            tick();
            e = q.pop_front();
            n_chk++;
            if ({hs, ls, sh} !== e) begin
                n_fail++;
                $display("FAIL short t=%0d got hs=%b ls=%b sh=%b exp hs=%b ls=%b sh=%b",
                         t, hs, ls, sh, e.hs, e.ls, e.sh);
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_zero_pol();
        logic on2;
        cfg(0, 0, 1'b1, 1'b1);
        n_chk++;
        if (hs !== 4'h0 || ls !== 4'hF) begin
            n_fail++;
            $display("FAIL pol_delay got hs=%b ls=%b exp hs=0000 ls=1111", hs, ls);
        end
        for (int t = 0; t < 8; t++) begin
            pwm[2] = (t >= 1 && t < 4);
            en     = (t < 6);
            on2    = (t >= 2 && t <= 4);
            if (t >= 6) begin
                e.hs = 4'hF;
                e.ls = 4'hF;
            end else begin
                e.hs = {1'b1, !on2, 2'b11};
                e.ls = {1'b0, on2, 2'b00};
            end
            e.sh = 4'h0;
            q.push_back(e);
            tick();
            e = q.pop_front();
            n_chk++;
            if ({hs, ls, sh} !== e) begin
                n_fail++;
                $display("FAIL zero_pol t=%0d got hs=%b ls=%b sh=%b exp hs=%b ls=%b sh=%b",
                         t, hs, ls, sh, e.hs, e.ls, e.sh);
            end
        end
        cfg(4, 4, 1'b0, 1'b0);
    endtask

    task automatic test_mid();
        logic h0;
        logic l0;
        logic lo;
        for (int t = 0; t < 43; t++) begin
            pwm[0] = (t >= 6 && t < 15) || (t >= 22 && t < 30);
            en     = (t != 8);
            upd    = (t == 17);
            if (t == 17) begin
                dtf = W'(10);
            end
            if (t < 6) begin
                h0 = 1'b0;
                l0 = (t >= 4);
                lo = (t >= 4);
            end else if (t >= 8 && t <= 12) begin
                h0 = 1'b0;
                l0 = 1'b0;
                lo = 1'b0;
            end else begin
                h0 = (t >= 13 && t <= 15) || (t >= 27 && t <= 30);
                l0 = (t == 6) || (t >= 20 && t <= 22) || (t >= 41);
                lo = 1'b1;
            end
            e.hs = {3'b000, h0};
            e.ls = {{3{lo}}, l0};
            e.sh = 4'h0;
            q.push_back(e);
            tick();
            e = q.pop_front();
            n_chk++;
            if ({hs, ls, sh} !== e) begin
                n_fail++;
                $display("FAIL mid t=%0d got hs=%b ls=%b sh=%b exp hs=%b ls=%b sh=%b",
                         t, hs, ls, sh, e.hs, e.ls, e.sh);
            end
        end
        upd = 1'b0;
    endtask

    task automatic test_reset_mid();
        cfg(4, 4, 1'b0, 1'b0);
        for (int t = 0; t < 7; t++) begin
            pwm[0] = 1'b1;
            pwm[3] = (t == 0);
            e.hs = (t >= 5) ? 4'b0001 : 4'b0000;
            e.ls = (t == 0) ? 4'b1111 : (t == 1) ? 4'b0110 : 4'b1110;
            e.sh = (t >= 2) ? 4'b1000 : 4'b0000;
            q.push_back(e);
            tick();
            e = q.pop_front();
            n_chk++;
            if ({hs, ls, sh} !== e) begin
                n_fail++;
                $display("FAIL pre_rst t=%0d got hs=%b ls=%b sh=%b exp hs=%b ls=%b sh=%b",
                         t, hs, ls, sh, e.hs, e.ls, e.sh);
            end
        end
        #2 rstn = 1'b0;
        #1;
        q.push_back('0);
        e = q.pop_front();
        n_chk++;
        if ({hs, ls, sh} !== e) begin
            n_fail++;
            $display("FAIL async_rst got hs=%b ls=%b sh=%b exp all zero", hs, ls, sh);
        end
        en   = 1'b0;
        pwm  = 4'b0001;
        tick();
        #2 rstn = 1'b1;
        q.push_back('0);
        tick();
        e = q.pop_front();
        n_chk++;
        if ({hs, ls, sh} !== e) begin
            n_fail++;
            $display("FAIL post_rst got hs=%b ls=%b sh=%b exp all zero", hs, ls, sh);
        end
        en = 1'b1;
        e.hs = 4'b0001;
        e.ls = 4'b1110;
        e.sh = 4'b0000;
        q.push_back(e);
        tick();
        e = q.pop_front();
        n_chk++;
        if ({hs, ls, sh} !== e) begin
            n_fail++;
            $display("FAIL shadow_rst got hs=%b ls=%b sh=%b exp hs=%b ls=%b sh=%b",
                     hs, ls, sh, e.hs, e.ls, e.sh);
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_steady();
        test_short();
        test_zero_pol();
        test_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
